syscon_clkdiv: RTL
==================

# syscon_clkdiv

Multi-channel, runtime-programmable clock-enable generator for the syscon domain. It runs from the single system clock and models the oscillator enable/power-up handshake with a startup delay. It produces per-channel single-cycle tick strobes and a square-wave phase bit per channel at arbitrary integer divide ratios. Peripherals (UART baud, timers, LED PWM) consume the ticks instead of deriving their own clocks.

## Interface
- `CHANNELS`, 2: number of independent divider channels (≥1).
- `DIV_W`, 16: width of each divide-ratio field.
- `DIV_RESET`, 7: reset divide value per channel; period = value+1, so 7 gives ÷8.
- `STARTUP_CYCLES`, 64: cycles from power-up request to `ready` (≥1).

- `clk`  in  1  system clock; sole clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `pu`  in  1  power-up request, level-sensitive.
- `en`  in  1  tick enable; freezes all channels when low.
- `div_i`  in  CHANNELS*DIV_W  new divide values; channel n occupies bits [n*DIV_W +: DIV_W].
- `div_load`  in  CHANNELS  one-cycle strobe per channel that latches its `div_i` field.
- `ready`  out  1  high only in RUN.
- `tick`  out  CHANNELS  one-cycle strobe at the end of each period.
- `phase`  out  CHANNELS  toggles on every tick, giving a 50% square wave at period*2.

## Operation
- FSM states: OFF, STARTUP, RUN.
  - OFF→STARTUP when `pu`=1.
  - STARTUP→RUN when the startup counter reaches STARTUP_CYCLES-1.
  - Any state→OFF when `pu`=0; this takes priority over all other transitions.
- Startup counter is cleared on entry to STARTUP.
- Per channel, registers:
  - `div_q` holds the active divide value.
  - `pend_q` and `pend_v` hold a pending divide value and its valid flag.
  - `cnt` is a DIV_W-bit counter.
- `div_load[n]`=1 writes `pend_q`←field and sets `pend_v`. A later load before it is applied overwrites the pending value (last write wins).
- Outside RUN:
  - A pending value is applied immediately on the next edge.
  - `cnt` is held at 0.
  - `tick`=0; `phase` holds its value.
- In RUN with `en`=1:
  - When `cnt`==`div_q`, the channel asserts `tick` next cycle, toggles `phase`, and sets `cnt`←0.
  - If `pend_v`, the same edge also sets `div_q`←`pend_q` and clears `pend_v`.
  - Otherwise `cnt`++.
- In RUN with `en`=0: `cnt` and `phase` hold, `tick`=0, and loads still latch into pending.
- `div_q`=0 means a tick on every cycle while enabled.
- Load and period-end in the same cycle: the value loaded that cycle is not applied at that boundary; it applies at the following boundary.
- Leaving RUN (`pu`=0) mid-period discards the partial count. The next RUN starts at `cnt`=0.

## Timing
- Reset values: state=OFF, `ready`=0, `tick`=0, `phase`=0, `cnt`=0, `div_q`=DIV_RESET, `pend_v`=0.
- `rst` overrides everything, including a coincident `div_load`.
- `pu` rises before edge k: STARTUP after edge k; `ready`=1 after edge k+STARTUP_CYCLES.
- First tick after `ready` rises (`en`=1 throughout): `tick` high in the cycle beginning div_q+1 edges after the edge that set `ready`.
- Steady state: tick period is exactly div_q+1 cycles and `tick` is one cycle wide.
- `pu` falls before edge j: `ready`=0 and `tick`=0 after edge j.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `syscon_pkg`:
  - state enum `clkdiv_state_t` (OFF, STARTUP, RUN);
  - default constants `SYSCON_DIV_RESET`, `SYSCON_STARTUP_CYCLES`.
- Sub-module `syscon_clkdiv_chan` holds one channel's `div_q`, `pend_q`, `pend_v`, `cnt`, `tick`, `phase`. It takes `run` and `en` from the parent.
- The parent holds the FSM and startup counter and instantiates `syscon_clkdiv_chan` via generate, CHANNELS times.

## Test plan
- Reset, then `pu`=1 with STARTUP_CYCLES=64 → `ready` rises exactly 64 edges later; ch0 (DIV_RESET=7) tick every 8 cycles, `phase` period 16.
- ch1 `div_i`=2 loaded mid-period while ch0 is at ÷8 → ch1 finishes its old ÷8 period, then ticks every 3 cycles; ch0 is unaffected.
- `div_load` coincident with a tick, value 0 → one more period at the old value, then a tick every cycle.
- `en` low for 5 cycles mid-period → tick delayed by exactly 5 cycles; `phase` holds.
- `pu` dropped mid-period, then raised again → `ready`=0 next cycle, no ticks; after 64 cycles the first tick comes a full div_q+1 after `ready`.
- `rst` asserted in RUN with `div_load` active → all outputs at reset values, `div_q`=7, pending value discarded.

Source files
------------

// File: rtl/syscon_pkg.sv
// rtl/syscon_pkg.sv - shared syscon types and default constants
package syscon_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        STARTUP = 2'd1,
        RUN     = 2'd2
    } clkdiv_state_t;

    localparam int SYSCON_DIV_RESET      = 7;
    localparam int SYSCON_STARTUP_CYCLES = 64;

endpackage

// File: rtl/syscon_clkdiv_if.sv
// rtl/syscon_clkdiv_if.sv - control/status bundle of the clock-enable generator
interface syscon_clkdiv_if #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16
);
    logic                      pu;
    logic                      en;
    logic [CHANNELS*DIV_W-1:0] div_i;
    logic [CHANNELS-1:0]       div_load;
    logic                      ready;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       phase;

    modport master (
        output pu, en, div_i, div_load,
        input  ready, tick, phase
    );

    modport slave (
        input  pu, en, div_i, div_load,
        output ready, tick, phase
    );
endinterface

// File: rtl/syscon_clkdiv_chan.sv
// rtl/syscon_clkdiv_chan.sv - one divider channel with double-buffered divide value
module syscon_clkdiv_chan #(
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             en,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load,
    output logic             tick,
    output logic             phase
);
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_q;
    logic             pend_v;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DIV_W'(DIV_RESET);
            pend_q <= '0;
            pend_v <= 1'b0;
            cnt    <= '0;
            tick   <= 1'b0;
            phase  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (!run) begin
                cnt <= '0;
                if (pend_v) begin
                    div_q  <= pend_q;
                    pend_v <= 1'b0;
                end
            end else if (en) begin
                if (cnt == div_q) begin
                    tick  <= 1'b1;
                    phase <= ~phase;
                    cnt   <= '0;
                    if (pend_v) begin
                        div_q  <= pend_q;
                        pend_v <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // A load in the same cycle as a boundary stays pending for the next one.
            if (div_load) begin
                pend_q <= div_i;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/syscon_clkdiv.sv
// rtl/syscon_clkdiv.sv - oscillator power-up FSM plus CHANNELS tick/phase dividers
module syscon_clkdiv
    import syscon_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int DIV_W          = 16,
    parameter int DIV_RESET      = SYSCON_DIV_RESET,
    parameter int STARTUP_CYCLES = SYSCON_STARTUP_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    syscon_clkdiv_if.slave bus
);
    localparam int SW = $clog2(STARTUP_CYCLES + 1);

    clkdiv_state_t       state_q, state_d;
    logic [SW-1:0]       scnt_q;
    logic                run;
    logic [CHANNELS-1:0] tick_w;
    logic [CHANNELS-1:0] phase_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     if (bus.pu) state_d = STARTUP;
            STARTUP: if (scnt_q == SW'(STARTUP_CYCLES - 1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = OFF;
        endcase
        if (!bus.pu) begin
            state_d = OFF;
        end
    end

    // Held at zero outside STARTUP so every entry starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || state_q != STARTUP) begin
            scnt_q <= '0;
        end else begin
            scnt_q <= scnt_q + 1'b1;
        end
    end

    // Qualified with pu so the edge that drops RUN already suppresses ticks.
    assign run       = (state_q == RUN) && bus.pu;
    assign bus.ready = (state_q == RUN);
    assign bus.tick  = tick_w;
    assign bus.phase = phase_w;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        syscon_clkdiv_chan #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .run      (run),
            .en       (bus.en),
            .div_i    (bus.div_i[g*DIV_W +: DIV_W]),
            .div_load (bus.div_load[g]),
            .tick     (tick_w[g]),
            .phase    (phase_w[g])
        );
    end
endmodule
